// File: rtl/tdd_pkg.sv
// Shared definitions for the TDD frame timer.
//   tdd_state_e   : frame timer state (IDLE, RUN)
//   MIN_FRAME_LEN : shortest frame the timer will ever generate
//   CNT_W_DEFAULT : default width of lengths, window bounds and position
package tdd_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;
  localparam int unsigned MIN_FRAME_LEN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdd_state_e;

endpackage

// File: rtl/tdd_window.sv
// Position-in-window test with wrap past the end of the frame.
//   win_start : first position inside the window
//   win_end   : first position past the window (exclusive)
//   pos       : position under test
//   hit       : 1 when pos lies inside the window
// A window whose start exceeds its end wraps through the frame boundary;
// equal bounds describe an empty window.
module tdd_window
  import tdd_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic [CNT_W-1:0] win_start,
  input  logic [CNT_W-1:0] win_end,
  input  logic [CNT_W-1:0] pos,
  output logic             hit
);

  always_comb begin
    hit = 1'b0;
    if (win_start < win_end) begin
      hit = (pos >= win_start) && (pos < win_end);
    end else if (win_start > win_end) begin
      hit = (pos >= win_start) || (pos < win_end);
    end
  end

endmodule

// File: rtl/tdd_frame_ctrl.sv
// TDD frame timer feeding the DMA bridge capture/playout enables.
//   clk, rst_n         : sample clock, synchronous active-low reset
//   run                : level, frame timer running
//   tddmode            : 1 = windowed enables, 0 = continuous enables
//   frame_len          : frame length in samples
//   tstart/tend        : TX (oen) window, end exclusive
//   rstart/rend        : RX (ien) window, end exclusive
//   frame_adj, adj_req : signed one-shot length delta and its capture strobe
//   ien, oen, sync     : registered enables and frame-start pulse
//   frame_pos          : sample index within the current frame
//   frame_num          : frames started since run rose
//   adj_pending        : adjustment captured but not yet applied
// Configuration is shadowed at every frame start so software writes only take
// effect on the next frame. All outputs come straight from flops.
module tdd_frame_ctrl
  import tdd_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned NUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             tddmode,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [CNT_W-1:0] tstart,
  input  logic [CNT_W-1:0] tend,
  input  logic [CNT_W-1:0] rstart,
  input  logic [CNT_W-1:0] rend,
  input  logic [CNT_W-1:0] frame_adj,
  input  logic             adj_req,
  output logic             ien,
  output logic             oen,
  output logic             sync,
  output logic [CNT_W-1:0] frame_pos,
  output logic [NUM_W-1:0] frame_num,
  output logic             adj_pending
);

  // Two guard bits: frame_len is unsigned CNT_W, the delta is signed CNT_W.
  localparam int unsigned SumW = CNT_W + 2;
  localparam logic signed [SumW-1:0] SumMin = SumW'(MIN_FRAME_LEN);
  localparam logic signed [SumW-1:0] SumMax = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] LenMin = CNT_W'(MIN_FRAME_LEN);

  tdd_state_e state_q, state_d;

  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] eff_len_q, eff_len_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             sync_q, sync_d;
  logic             ien_q, ien_d;
  logic             oen_q, oen_d;
  logic [CNT_W-1:0] adj_val_q, adj_val_d;
  logic             adj_pending_q, adj_pending_d;

  // Shadowed configuration for the frame in progress.
  logic [CNT_W-1:0] tstart_q, tstart_d;
  logic [CNT_W-1:0] tend_q, tend_d;
  logic [CNT_W-1:0] rstart_q, rstart_d;
  logic [CNT_W-1:0] rend_q, rend_d;
  logic             tdd_q, tdd_d;

  logic                   at_boundary;
  logic                   new_frame;
  logic                   apply_adj;
  logic signed [SumW-1:0] adj_sum;
  logic [CNT_W-1:0]       adj_len;
  logic [CNT_W-1:0]       base_len;
  logic                   tx_hit;
  logic                   rx_hit;

  assign at_boundary = (pos_q == eff_len_q - CNT_W'(1));

  assign base_len = (frame_len < LenMin) ? LenMin : frame_len;

  assign adj_sum = $signed({2'b00, frame_len}) +
                   $signed({{2{adj_val_q[CNT_W-1]}}, adj_val_q});

  always_comb begin
    adj_len = adj_sum[CNT_W-1:0];
    if (adj_sum < SumMin) begin
      adj_len = LenMin;
    end else if (adj_sum > SumMax) begin
      adj_len = '1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    num_d     = num_q;
    sync_d    = 1'b0;
    eff_len_d = eff_len_q;
    tstart_d  = tstart_q;
    tend_d    = tend_q;
    rstart_d  = rstart_q;
    rend_d    = rend_q;
    tdd_d     = tdd_q;
    new_frame = 1'b0;
    apply_adj = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d   = RUN;
          new_frame = 1'b1;
          num_d     = '0;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          pos_d   = '0;
        end else if (at_boundary) begin
          new_frame = 1'b1;
          // A pending adjustment is only consumed at a boundary, never at entry.
          apply_adj = adj_pending_q;
          num_d     = num_q + NUM_W'(1);
        end else begin
          pos_d = pos_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_frame) begin
      pos_d     = '0;
      sync_d    = 1'b1;
      eff_len_d = apply_adj ? adj_len : base_len;
      tstart_d  = tstart;
      tend_d    = tend;
      rstart_d  = rstart;
      rend_d    = rend;
      tdd_d     = tddmode;
    end

    // A request in the same cycle as a boundary is held for the next one.
    if (adj_req) begin
      adj_val_d     = frame_adj;
      adj_pending_d = 1'b1;
    end else begin
      adj_val_d     = adj_val_q;
      adj_pending_d = adj_pending_q & ~apply_adj;
    end
  end

  // Windows look at next-cycle position and config so the registered enables
  // line up with the registered frame_pos.
  tdd_window #(
    .CNT_W(CNT_W)
  ) u_tx_window (
    .win_start(tstart_d),
    .win_end  (tend_d),
    .pos      (pos_d),
    .hit      (tx_hit)
  );

  tdd_window #(
    .CNT_W(CNT_W)
  ) u_rx_window (
    .win_start(rstart_d),
    .win_end  (rend_d),
    .pos      (pos_d),
    .hit      (rx_hit)
  );

  always_comb begin
    ien_d = 1'b0;
    oen_d = 1'b0;
    if (state_d == RUN) begin
      if (tdd_d) begin
        ien_d = rx_hit;
        oen_d = tx_hit;
      end else begin
        ien_d = 1'b1;
        oen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      eff_len_q     <= '0;
      num_q         <= '0;
      sync_q        <= 1'b0;
      ien_q         <= 1'b0;
      oen_q         <= 1'b0;
      adj_val_q     <= '0;
      adj_pending_q <= 1'b0;
      tstart_q      <= '0;
      tend_q        <= '0;
      rstart_q      <= '0;
      rend_q        <= '0;
      tdd_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      eff_len_q     <= eff_len_d;
      num_q         <= num_d;
      sync_q        <= sync_d;
      ien_q         <= ien_d;
      oen_q         <= oen_d;
      adj_val_q     <= adj_val_d;
      adj_pending_q <= adj_pending_d;
      tstart_q      <= tstart_d;
      tend_q        <= tend_d;
      rstart_q      <= rstart_d;
      rend_q        <= rend_d;
      tdd_q         <= tdd_d;
    end
  end

  assign ien         = ien_q;
  assign oen         = oen_q;
  assign sync        = sync_q;
  assign frame_pos   = pos_q;
  assign frame_num   = num_q;
  assign adj_pending = adj_pending_q;

endmodule
